// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single data-memory port between the CPU M stage
// (master 0) and an auxiliary bus master (master 1, DMA/debug loader).
// The optional starvation guard is built only when DBUS_ARB_STARVE_EN is defined.
// Handshake: a master drives req with a stable payload. A gnt in the same
// cycle means the port carries that access now, and a write commits on the
// rising edge that closes the cycle. Without gnt the master holds its payload
// and retries; the CPU sees this as cpu_stall.
module dbus_arbiter #(
    parameter int MAX_WAIT  = 4,
    parameter int BURST_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_byteen,
    output logic        cpu_stall,
    output logic        cpu_gnt,
    output logic [31:0] cpu_rdata,
    input  logic        aux_req,
    input  logic        aux_lock,
    input  logic [31:0] aux_addr,
    input  logic [31:0] aux_wdata,
    input  logic [3:0]  aux_byteen,
    output logic        aux_gnt,
    output logic [31:0] aux_rdata,
    output logic [31:0] m_data_addr,
    output logic [31:0] m_data_wdata,
    output logic [3:0]  m_data_byteen,
    input  logic [31:0] m_data_rdata
);

    // Parameters outside 1..15 cannot be held by the 4-bit counters.
    if (MAX_WAIT < 1 || MAX_WAIT > 15 || BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_params
        $error("dbus_arbiter: MAX_WAIT and BURST_MAX must be in 1..15");
    end

    typedef enum logic {
        IDLE     = 1'b0,
        AUX_LOCK = 1'b1
    } state_t;

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);
    // A one-beat burst limit means a lock can never extend ownership.
    localparam bit LOCK_OK = (BURST_MAX > 1);

    state_t     state_q, state_d;
    logic [3:0] beats_q, beats_d;
    logic       force_aux;
    logic       cpu_gnt_c;
    logic       aux_gnt_c;

`ifdef DBUS_ARB_STARVE_EN
    localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic       post_rel_q;

    // Count consecutive denied aux cycles; remember the cycle after a burst ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= 4'd0;
            post_rel_q <= 1'b0;
        end else begin
            if (!aux_req || aux_gnt_c) begin
                wait_cnt_q <= 4'd0;
            end else if (wait_cnt_q != WAIT_LIM) begin
                wait_cnt_q <= wait_cnt_q + 4'd1;
            end
            post_rel_q <= (state_q == AUX_LOCK) && (state_d == IDLE);
        end
    end

    // The post-release cycle belongs to the CPU, so the guard stays quiet then.
    assign force_aux = (wait_cnt_q == WAIT_LIM) && !post_rel_q;
`else
    // Strict CPU priority in IDLE; aux may starve.
    assign force_aux = 1'b0;
`endif

    // FSM and beat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beats_q <= 4'd0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
        end
    end

    // Grant decision and next state; a reset cycle grants nothing.
    always_comb begin
        state_d   = state_q;
        beats_d   = beats_q;
        cpu_gnt_c = 1'b0;
        aux_gnt_c = 1'b0;
        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (cpu_req && !force_aux) begin
                        cpu_gnt_c = 1'b1;
                    end else if (aux_req) begin
                        aux_gnt_c = 1'b1;
                        if (aux_lock && LOCK_OK) begin
                            state_d = AUX_LOCK;
                            beats_d = 4'd1;
                        end
                    end
                end
                AUX_LOCK: begin
                    if (aux_req) begin
                        aux_gnt_c = 1'b1;
                        // The beat reaching BURST_MAX releases regardless of aux_lock.
                        if (!aux_lock || (beats_q + 4'd1 == BURST_LIM)) begin
                            state_d = IDLE;
                            beats_d = 4'd0;
                        end else begin
                            beats_d = beats_q + 4'd1;
                        end
                    end else begin
                        state_d = IDLE;
                        beats_d = 4'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    beats_d = 4'd0;
                end
            endcase
        end
    end

    assign cpu_gnt   = cpu_gnt_c;
    assign aux_gnt   = aux_gnt_c;
    assign cpu_stall = cpu_req && !cpu_gnt_c && !reset;

    // Port mux; zero byte enables with no grant so an idle cycle never writes.
    always_comb begin
        m_data_addr   = 32'd0;
        m_data_wdata  = 32'd0;
        m_data_byteen = 4'd0;
        cpu_rdata     = 32'd0;
        aux_rdata     = 32'd0;
        if (cpu_gnt_c) begin
            m_data_addr   = cpu_addr;
            m_data_wdata  = cpu_wdata;
            m_data_byteen = cpu_byteen;
            cpu_rdata     = m_data_rdata;
        end else if (aux_gnt_c) begin
            m_data_addr   = aux_addr;
            m_data_wdata  = aux_wdata;
            m_data_byteen = aux_byteen;
            aux_rdata     = m_data_rdata;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed stimulus for dbus_arbiter with a behavioural
// owner-of-the-port model checked every cycle, plus hand-computed pins.
module tb_dbus_arbiter;

    localparam int MAX_WAIT  = 4;
    localparam int BURST_MAX = 8;

    logic        clk;
    logic        reset;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_stall;
    logic        cpu_gnt;
    logic [31:0] cpu_rdata;
    logic        aux_req;
    logic        aux_lock;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdata;
    logic [3:0]  aux_byteen;
    logic        aux_gnt;
    logic [31:0] aux_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    int checks   = 0;
    int failures = 0;

    // Memory read data is a fixed function of the address.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    assign m_data_rdata = mem_fn(m_data_addr);

    dbus_arbiter #(
        .MAX_WAIT  (MAX_WAIT),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cpu_req       (cpu_req),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_byteen    (cpu_byteen),
        .cpu_stall     (cpu_stall),
        .cpu_gnt       (cpu_gnt),
        .cpu_rdata     (cpu_rdata),
        .aux_req       (aux_req),
        .aux_lock      (aux_lock),
        .aux_addr      (aux_addr),
        .aux_wdata     (aux_wdata),
        .aux_byteen    (aux_byteen),
        .aux_gnt       (aux_gnt),
        .aux_rdata     (aux_rdata),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_data_rdata  (m_data_rdata)
    );

    // Clock and initial reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        reset      = 1'b1;
        cpu_req    = 1'b0;
        cpu_addr   = 32'd0;
        cpu_wdata  = 32'd0;
        cpu_byteen = 4'd0;
        aux_req    = 1'b0;
        aux_lock   = 1'b0;
        aux_addr   = 32'd0;
        aux_wdata  = 32'd0;
        aux_byteen = 4'd0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of inputs just after the rising edge.
    task automatic step(input bit rst, input bit creq, input logic [31:0] caddr,
                        input logic [3:0] cbe, input bit areq, input bit alock,
                        input logic [31:0] aaddr, input logic [3:0] abe);
        @(posedge clk);
        #1;
        reset      = rst;
        cpu_req    = creq;
        cpu_addr   = caddr;
        cpu_wdata  = caddr ^ 32'h5555_0000;
        cpu_byteen = cbe;
        aux_req    = areq;
        aux_lock   = alock;
        aux_addr   = aaddr;
        aux_wdata  = aaddr ^ 32'hAAAA_0000;
        aux_byteen = abe;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 32'd0, 4'd0);
    endtask

    // Model state: beats taken in the current locked burst (0 = none),
    // consecutive denied aux cycles, and whether this cycle follows a burst.
    int m_burst   = 0;
    int m_waited  = 0;
    bit m_after   = 1'b0;

    // Who owns the port this cycle: 0 nobody, 1 CPU, 2 aux.
    function automatic int model_owner();
        bit starve;
        if (reset) return 0;
        if (m_burst > 0) return aux_req ? 2 : 0;
`ifdef DBUS_ARB_STARVE_EN
        starve = (m_waited == MAX_WAIT) && !m_after;
`else
        starve = 1'b0;
`endif
        if (cpu_req && !starve) return 1;
        if (aux_req) return 2;
        return 0;
    endfunction

    // Scoreboard: compare every cycle mid-period, then advance the model.
    initial begin : cmp_proc
        int          owner;
        bit          was;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
        forever begin
            @(negedge clk);
            owner   = model_owner();
            e_addr  = (owner == 1) ? cpu_addr   : (owner == 2) ? aux_addr   : 32'd0;
            e_wdata = (owner == 1) ? cpu_wdata  : (owner == 2) ? aux_wdata  : 32'd0;
            e_be    = (owner == 1) ? cpu_byteen : (owner == 2) ? aux_byteen : 4'd0;
            chk("cpu_gnt",   32'(cpu_gnt),   32'(owner == 1));
            chk("aux_gnt",   32'(aux_gnt),   32'(owner == 2));
            chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !reset && owner != 1));
            chk("m_addr",    m_data_addr,    e_addr);
            chk("m_wdata",   m_data_wdata,   e_wdata);
            chk("m_byteen",  32'(m_data_byteen), 32'(e_be));
            chk("cpu_rdata", cpu_rdata, (owner == 1) ? mem_fn(e_addr) : 32'd0);
            chk("aux_rdata", aux_rdata, (owner == 2) ? mem_fn(e_addr) : 32'd0);
            if (reset) begin
                m_burst  = 0;
                m_waited = 0;
                m_after  = 1'b0;
            end else begin
                was = (m_burst > 0);
                if (owner == 2) begin
                    if (!was) begin
                        if (aux_lock && BURST_MAX > 1) m_burst = 1;
                    end else if (!aux_lock || m_burst + 1 == BURST_MAX) begin
                        m_burst = 0;
                    end else begin
                        m_burst++;
                    end
                end else if (was) begin
                    m_burst = 0;
                end
                m_after = was && (m_burst == 0);
                if (!aux_req || owner == 2) m_waited = 0;
                else if (m_waited < MAX_WAIT) m_waited++;
            end
        end
    end

    // Directed sequence with hand-computed pins.
    initial begin : main_proc
        int beat_cnt;
        logic [31:0] a;

        // Reset holds everything off even with both masters requesting.
        step(1'b1, 1'b1, 32'h40, 4'hF, 1'b1, 1'b0, 32'h80, 4'h3);
        @(negedge clk);
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_aux_gnt", 32'(aux_gnt), 32'd0);
        chk("rst_byteen",  32'(m_data_byteen), 32'd0);
        chk("rst_stall",   32'(cpu_stall), 32'd0);
        step(1'b0, 1'b1, 32'h10, 4'h0, 1'b0, 1'b0, 32'd0, 4'd0);
        @(negedge clk);
        chk("post_rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("post_rst_addr",    m_data_addr, 32'h10);
        idle();

`ifdef DBUS_ARB_STARVE_EN
        // Both held: four CPU cycles, then aux forced once, then CPU.
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 1'b1, 32'h20, 4'hF, 1'b1, 1'b0, 32'h30, 4'h0);
            @(negedge clk);
            if (c == 5) begin
                chk("starve_aux_gnt", 32'(aux_gnt), 32'd1);
                chk("starve_stall",   32'(cpu_stall), 32'd1);
            end else begin
                chk("starve_cpu_gnt", 32'(cpu_gnt), 32'd1);
            end
        end
`else
        // Both held: CPU always wins; aux gets the port once CPU drops.
        for (int c = 1; c <= 6; c++) begin
            step(1'b0, 1'b1, 32'h20, 4'hF, 1'b1, 1'b0, 32'h30, 4'h0);
            @(negedge clk);
            chk("tie_cpu_gnt", 32'(cpu_gnt), 32'd1);
            chk("tie_aux_gnt", 32'(aux_gnt), 32'd0);
        end
`endif
        step(1'b0, 1'b0, 32'h20, 4'h0, 1'b1, 1'b0, 32'h30, 4'h0);
        @(negedge clk);
        chk("drop_aux_gnt",   32'(aux_gnt), 32'd1);
        chk("drop_aux_rdata", aux_rdata, 32'h0030_FFCF);
        idle();

        // Locked write burst 0x100..0x11C, CPU waiting from beat 2 on.
        beat_cnt = 0;
        for (int b = 0; b <= 8; b++) begin
            a = 32'h100 + 32'(4 * b);
            step(1'b0, b != 0, 32'h40, 4'h0, 1'b1, 1'b1, a, 4'hF);
            @(negedge clk);
            if (aux_gnt && m_data_byteen != 4'd0) beat_cnt++;
            if (b >= 1 && b <= 7) chk("burst_stall", 32'(cpu_stall), 32'd1);
            if (b == 8) chk("burst_cpu_after", 32'(cpu_gnt), 32'd1);
        end
        chk("burst_beats", 32'(beat_cnt), 32'd8);
        idle();

        // Early release: lock dropped on beat 3, CPU takes the next cycle.
        for (int b = 0; b <= 3; b++) begin
            a = 32'h200 + 32'(4 * b);
            step(1'b0, b != 0, 32'h48, 4'h0, 1'b1, b != 2, a, 4'h3);
            @(negedge clk);
            if (b == 2) chk("early_beat3_aux", 32'(aux_gnt), 32'd1);
            if (b == 3) chk("early_cpu_gnt",   32'(cpu_gnt), 32'd1);
        end
        idle();

        // Reset on beat 4 of a locked burst aborts it without writing.
        for (int b = 0; b <= 2; b++) begin
            step(1'b0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h280 + 32'(4 * b), 4'hF);
        end
        step(1'b1, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h28C, 4'hF);
        @(negedge clk);
        chk("midrst_byteen",  32'(m_data_byteen), 32'd0);
        chk("midrst_aux_gnt", 32'(aux_gnt), 32'd0);
        step(1'b0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 32'h300, 4'hF);
        @(negedge clk);
        chk("after_rst_aux_gnt", 32'(aux_gnt), 32'd1);
        step(1'b0, 1'b1, 32'h44, 4'h0, 1'b1, 1'b0, 32'h304, 4'hF);
        @(negedge clk);
        chk("single_beat_cpu_gnt", 32'(cpu_gnt), 32'd1);

        // Locked burst abandoned by dropping aux_req: no grant that cycle.
        step(1'b0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b1, 32'h400, 4'h1);
        step(1'b0, 1'b1, 32'h50, 4'h2, 1'b0, 1'b0, 32'd0, 4'h0);
        @(negedge clk);
        chk("abandon_no_cpu", 32'(cpu_gnt), 32'd0);
        chk("abandon_stall",  32'(cpu_stall), 32'd1);
        step(1'b0, 1'b1, 32'h50, 4'h2, 1'b1, 1'b0, 32'h404, 4'h1);
        @(negedge clk);
        chk("abandon_cpu_next", 32'(cpu_gnt), 32'd1);
        idle();
        idle();

        @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
